// File: rtl/xor_net_sequencer_if.sv
// Bus between the XOR-network sequencer and its environment: input pair,
// hidden/output neuron control and result handshake.
interface xor_net_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                         in_valid;
   logic                         in_ready;
   logic signed [DATA_WIDTH-1:0] in_x1;
   logic signed [DATA_WIDTH-1:0] in_x2;
   logic                         nn_en;
   logic                         hid_run;
   logic signed [DATA_WIDTH-1:0] hid_x1;
   logic signed [DATA_WIDTH-1:0] hid_x2;
   logic signed [DATA_WIDTH-1:0] hid_y1;
   logic signed [DATA_WIDTH-1:0] hid_y2;
   logic                         hid_rdy1;
   logic                         hid_rdy2;
   logic                         out_run;
   logic signed [DATA_WIDTH-1:0] out_x1;
   logic signed [DATA_WIDTH-1:0] out_x2;
   logic signed [DATA_WIDTH-1:0] out_y;
   logic                         out_rdy;
   logic                         res_valid;
   logic                         res_ready;
   logic signed [DATA_WIDTH-1:0] res_y;
   logic                         res_bit;
   logic                         res_err;

   modport master (
      input  in_valid, in_x1, in_x2, hid_y1, hid_y2, hid_rdy1, hid_rdy2,
             out_y, out_rdy, res_ready,
      output in_ready, nn_en, hid_run, hid_x1, hid_x2, out_run, out_x1, out_x2,
             res_valid, res_y, res_bit, res_err
   );

   modport slave (
      output in_valid, in_x1, in_x2, hid_y1, hid_y2, hid_rdy1, hid_rdy2,
             out_y, out_rdy, res_ready,
      input  in_ready, nn_en, hid_run, hid_x1, hid_x2, out_run, out_x1, out_x2,
             res_valid, res_y, res_bit, res_err
   );
endinterface

// File: rtl/xor_net_sequencer.sv
// Sequences two hidden sigmoid neurons and one output neuron for one XOR
// evaluation; every bus output is a register driven from the next state.
module xor_net_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int FRAC_BITS  = 4,
   parameter int THRESH     = 1 << (FRAC_BITS - 1),
   parameter int TIMEOUT    = 31
) (
   input logic                 clk,
   input logic                 rst,
   xor_net_sequencer_if.master bus
);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic signed [DATA_WIDTH-1:0] THRESH_W = DATA_WIDTH'(THRESH);

   typedef enum logic [2:0] {
      IDLE, HID_RUN, HID_WAIT, OUT_RUN, OUT_WAIT, DONE
   } state_t;

   state_t                       state_q, state_d;
   logic                         in_ready_q, in_ready_d;
   logic                         hid_run_q, hid_run_d;
   logic                         out_run_q, out_run_d;
   logic                         res_valid_q, res_valid_d;
   logic signed [DATA_WIDTH-1:0] hid_x1_q, hid_x1_d, hid_x2_q, hid_x2_d;
   logic signed [DATA_WIDTH-1:0] out_x1_q, out_x1_d, out_x2_q, out_x2_d;
   logic signed [DATA_WIDTH-1:0] res_y_q, res_y_d;
   logic                         res_bit_q, res_bit_d, res_err_q, res_err_d;
   logic                         f1_q, f1_d, f2_q, f2_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;

   // NOTE: every register, including the datapath words, takes the async reset
   // so an aborted operation can never leak stale values downstream.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         hid_run_q   <= 1'b0;
         out_run_q   <= 1'b0;
         res_valid_q <= 1'b0;
         hid_x1_q    <= '0;
         hid_x2_q    <= '0;
         out_x1_q    <= '0;
         out_x2_q    <= '0;
         res_y_q     <= '0;
         res_bit_q   <= 1'b0;
         res_err_q   <= 1'b0;
         f1_q        <= 1'b0;
         f2_q        <= 1'b0;
         cnt_q       <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         hid_run_q   <= hid_run_d;
         out_run_q   <= out_run_d;
         res_valid_q <= res_valid_d;
         hid_x1_q    <= hid_x1_d;
         hid_x2_q    <= hid_x2_d;
         out_x1_q    <= out_x1_d;
         out_x2_q    <= out_x2_d;
         res_y_q     <= res_y_d;
         res_bit_q   <= res_bit_d;
         res_err_q   <= res_err_d;
         f1_q        <= f1_d;
         f2_q        <= f2_d;
         cnt_q       <= cnt_d;
      end
   end

   always_comb begin
      // NOTE: hold-value defaults first, so no path through the case infers a latch.
      state_d   = state_q;
      hid_x1_d  = hid_x1_q;
      hid_x2_d  = hid_x2_q;
      out_x1_d  = out_x1_q;
      out_x2_d  = out_x2_q;
      res_y_d   = res_y_q;
      res_bit_d = res_bit_q;
      res_err_d = res_err_q;
      f1_d      = f1_q;
      f2_d      = f2_q;
      cnt_d     = cnt_q;

      unique case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               hid_x1_d = bus.in_x1;
               hid_x2_d = bus.in_x2;
               state_d  = HID_RUN;
            end
         end
         HID_RUN: begin
            // Ready pulses seen here belong to an earlier launch.
            f1_d    = 1'b0;
            f2_d    = 1'b0;
            cnt_d   = '0;
            state_d = HID_WAIT;
         end
         HID_WAIT: begin
            if (bus.hid_rdy1) begin
               f1_d     = 1'b1;
               out_x1_d = bus.hid_y1;
            end
            if (bus.hid_rdy2) begin
               f2_d     = 1'b1;
               out_x2_d = bus.hid_y2;
            end
            if (f1_d && f2_d) begin
               state_d = OUT_RUN;
            end else if (cnt_q == CNT_LAST) begin
               res_y_d   = '0;
               res_bit_d = 1'b0;
               res_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         OUT_RUN: begin
            cnt_d   = '0;
            state_d = OUT_WAIT;
         end
         OUT_WAIT: begin
            if (bus.out_rdy) begin
               res_y_d   = bus.out_y;
               res_bit_d = (bus.out_y >= THRESH_W);
               res_err_d = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               res_y_d   = '0;
               res_bit_d = 1'b0;
               res_err_d = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            if (bus.res_ready) begin
               res_err_d = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake and strobe outputs are decoded from the next state so they are
   // registered yet line up exactly with the state they belong to.
   always_comb begin
      in_ready_d  = (state_d == IDLE);
      hid_run_d   = (state_d == HID_RUN);
      out_run_d   = (state_d == OUT_RUN);
      res_valid_d = (state_d == DONE);
   end

   assign bus.nn_en     = rst;
   assign bus.in_ready  = in_ready_q;
   assign bus.hid_run   = hid_run_q;
   assign bus.hid_x1    = hid_x1_q;
   assign bus.hid_x2    = hid_x2_q;
   assign bus.out_run   = out_run_q;
   assign bus.out_x1    = out_x1_q;
   assign bus.out_x2    = out_x2_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_y     = res_y_q;
   assign bus.res_bit   = res_bit_q;
   assign bus.res_err   = res_err_q;
endmodule

// File: tb/tb_xor_net_sequencer.sv
// Directed bench for xor_net_sequencer with stub neurons whose Ready pulse
// comes a programmable number of cycles after their Run cycle.
module tb_xor_net_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b0;

   xor_net_sequencer_if #(.DATA_WIDTH(8)) bus ();

   xor_net_sequencer #(
      .DATA_WIDTH(8), .FRAC_BITS(4), .THRESH(8), .TIMEOUT(31)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Stub neurons: Ready is high in cycle (run cycle + delay); delay 0 = never.
   logic signed [7:0] y_h1 = '0, y_h2 = '0, y_o = '0;
   int d_h1 = 7, d_h2 = 7, d_o = 7;
   int k_h, k_o;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_h <= 0;
         k_o <= 0;
      end else begin
         if (bus.hid_run) k_h <= 1;
         else if (k_h != 0 && k_h < 64) k_h <= k_h + 1;
         if (bus.out_run) k_o <= 1;
         else if (k_o != 0 && k_o < 64) k_o <= k_o + 1;
      end
   end

   assign bus.hid_rdy1 = (d_h1 != 0) && (k_h == d_h1);
   assign bus.hid_rdy2 = (d_h2 != 0) && (k_h == d_h2);
   assign bus.out_rdy  = (d_o != 0) && (k_o == d_o);
   assign bus.hid_y1   = y_h1;
   assign bus.hid_y2   = y_h2;
   assign bus.out_y    = y_o;

   // Monitors: run-strobe cycle counts and acceptance edges.
   int cyc = 0, n_hr = 0, n_or = 0, n_both = 0;
   int n_acc = 0, last_acc = 0, prev_acc = 0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus.hid_run) n_hr <= n_hr + 1;
      if (bus.out_run) n_or <= n_or + 1;
      if (bus.hid_run && bus.out_run) n_both <= n_both + 1;
      if (rst && bus.in_valid && bus.in_ready) begin
         n_acc    <= n_acc + 1;
         last_acc <= cyc;
         prev_acc <= last_acc;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   // Called at a negedge; returns at the negedge after the acceptance edge.
   task automatic send(input logic signed [7:0] x1, input logic signed [7:0] x2);
      int n;
      bus.in_x1    = x1;
      bus.in_x2    = x2;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_time", longint'(n < 100), 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic run_op(input logic signed [7:0] x1, input logic signed [7:0] x2,
                         input logic signed [7:0] hy1, input logic signed [7:0] hy2,
                         input int dh1, input int dh2,
                         input logic signed [7:0] oy, input int dout,
                         output int lat);
      y_h1 = hy1; y_h2 = hy2; y_o = oy;
      d_h1 = dh1; d_h2 = dh2; d_o = dout;
      send(x1, x2);
      lat = 0;
      while (!bus.res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic release_res();
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      check("post_done_valid", bus.res_valid, 0);
      check("post_done_ready", bus.in_ready, 1);
   endtask

   int lat, hr0, or0, acc0, n;
   logic signed [7:0] th_y[5] = '{8'sd7, 8'sd8, -8'sd16, 8'sd127, -8'sd1};
   logic th_b[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_x1     = '0;
      bus.in_x2     = '0;
      bus.res_ready = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_nn_en", bus.nn_en, 0);
      check("rst_strobes", {bus.hid_run, bus.out_run, bus.res_valid}, 0);
      check("rst_res", {bus.res_y, bus.res_bit, bus.res_err}, 0);
      check("rst_data", {bus.hid_x1, bus.hid_x2, bus.out_x1, bus.out_x2}, 0);
      rst = 1'b1;
      @(negedge clk);
      check("nn_en_run", bus.nn_en, 1);

      // Nominal: res_valid rises on the 16th edge after the acceptance edge
      // (the 17th counting the acceptance edge itself).
      hr0 = n_hr; or0 = n_or;
      run_op(8'sd16, 8'sd0, 8'sd14, 8'sd3, 7, 7, 8'sd12, 7, lat);
      check("nom_latency", lat, 16);
      check("nom_hid_x1", bus.hid_x1, 16);
      check("nom_out_x1", bus.out_x1, 14);
      check("nom_out_x2", bus.out_x2, 3);
      check("nom_res_y", bus.res_y, 12);
      check("nom_res_bit", bus.res_bit, 1);
      check("nom_res_err", bus.res_err, 0);
      check("nom_hid_run_cycles", n_hr - hr0, 1);
      check("nom_out_run_cycles", n_or - or0, 1);

      // Back-pressure: result and busy indication held; a waiting pair is not taken.
      acc0 = n_acc;
      bus.in_x1 = 8'sd1; bus.in_x2 = 8'sd1; bus.in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", bus.res_valid, 1);
         check("bp_res_y", bus.res_y, 12);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.in_valid = 1'b0;
      check("bp_no_accept", n_acc - acc0, 0);
      release_res();

      // Skewed Ready: rdy1 at +3, rdy2 at +7, single out_run after both.
      bus.res_ready = 1'b1;
      or0 = n_or;
      run_op(8'sd0, 8'sd16, 8'sd5, -8'sd3, 3, 7, 8'sd2, 7, lat);
      check("skew_latency", lat, 16);
      check("skew_out_x1", bus.out_x1, 5);
      check("skew_out_x2", bus.out_x2, -3);
      check("skew_res_y", bus.res_y, 2);
      check("skew_res_bit", bus.res_bit, 0);
      check("skew_out_run_cycles", n_or - or0, 1);
      @(negedge clk);

      // Throughput: back-to-back pairs with res_ready held high.
      y_h1 = 8'sd1; y_h2 = 8'sd1; y_o = 8'sd9; d_h1 = 7; d_h2 = 7; d_o = 7;
      send(8'sd16, 8'sd16);
      send(-8'sd16, 8'sd16);
      check("throughput", last_acc - prev_acc, 18);
      n = 0;
      while (!bus.res_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("tp_second_res_y", bus.res_y, 9);
      @(negedge clk);

      // Threshold edges, signed compare against 0.5.
      for (int i = 0; i < 5; i++) begin
         run_op(8'sd16, 8'sd0, 8'sd1, 8'sd1, 7, 7, th_y[i], 7, lat);
         check($sformatf("thresh_bit_%0d", th_y[i]), bus.res_bit, th_b[i]);
         check($sformatf("thresh_y_%0d", th_y[i]), bus.res_y, th_y[i]);
         @(negedge clk);
      end
      bus.res_ready = 1'b0;

      // Timeout: output neuron never answers; 1 OUT_RUN + 31 OUT_WAIT cycles.
      y_h1 = 8'sd2; y_h2 = 8'sd2; y_o = 8'sd12; d_h1 = 7; d_h2 = 7; d_o = 0;
      send(8'sd16, 8'sd0);
      n = 0;
      while (!bus.out_run && n < 100) begin
         @(negedge clk);
         n++;
      end
      lat = 0;
      while (!bus.res_valid && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check("to_latency", lat, 32);
      check("to_res_err", bus.res_err, 1);
      check("to_res_y", bus.res_y, 0);
      check("to_res_bit", bus.res_bit, 0);
      release_res();
      check("to_err_cleared", bus.res_err, 0);

      // Reset mid HID_WAIT aborts the operation.
      d_o = 7;
      or0 = n_or;
      send(8'sd16, 8'sd16);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_in_ready", bus.in_ready, 1);
      check("mid_rst_outputs",
            {bus.hid_run, bus.out_run, bus.res_valid, bus.res_bit, bus.res_err, bus.nn_en}, 0);
      check("mid_rst_data", {bus.hid_x1, bus.out_x1, bus.out_x2, bus.res_y}, 0);
      @(negedge clk);
      rst = 1'b1;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.res_valid) n++;
      end
      check("mid_rst_no_result", n, 0);
      check("mid_rst_no_out_run", n_or - or0, 0);
      check("runs_never_both", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
